z80_cycle_master: RTL and testbench

- Synchronous Z80 bus-cycle initiator: the driving end of the bus that our CPLD register blocks respond to.
- Generates opcode-fetch (M1 plus refresh), memory read/write and I/O read/write cycles with Z80 strobe ordering and WAIT handling.
- Used as an on-board bus exerciser or DMA sequencer, so the trap/ISR capture logic can be driven without a real CPU.
- One clock period equals one T-state.

---
 rtl/z80_cycle_master_if.sv | 36 +++
 rtl/z80_cycle_master.sv | 254 +++++++++++++++++++++++++
 tb/tb_z80_cycle_master.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_cycle_master_if.sv
// z80_cycle_master_if
//   Groups the request/response handshake and the Z80 bus signals used by
//   z80_cycle_master. The bidirectional data bus is not part of this bundle;
//   it is a plain inout port on the master.
//   master : the bus-cycle initiator (drives strobes, address, status)
//   slave  : the requester / bus model (drives req, cmd, addr_in, wdata, wait_n)
interface z80_cycle_master_if;
  logic        req;
  logic [2:0]  cmd;
  logic [15:0] addr_in;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rdata;
  logic        wait_n;
  logic [15:0] addr;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfsh_n;

  modport master (
    input  req, cmd, addr_in, wdata, wait_n,
    output busy, done, err, rdata, addr,
    output mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n
  );

  modport slave (
    output req, cmd, addr_in, wdata, wait_n,
    input  busy, done, err, rdata, addr,
    input  mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n
  );
endinterface

// File: rtl/z80_cycle_master.sv
// z80_cycle_master
//   Z80 bus-cycle initiator, one clock per T-state. Runs opcode fetch with
//   refresh, memory read/write and I/O read/write cycles with Z80 strobe
//   ordering, automatic I/O wait states, external WAIT and a wait timeout.
// Ports:
//   clk     : system clock, one T-state per period
//   reset_n : asynchronous active-low reset
//   bus     : handshake (req/cmd/addr_in/wdata -> busy/done/err/rdata) and
//             Z80 bus (wait_n in; addr and strobes out, all registered)
//   data    : Z80 data bus, driven only during write cycles T1..T3
module z80_cycle_master #(
  parameter int IO_AUTO_WAIT = 1,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  z80_cycle_master_if.master  bus,
  inout  wire  [7:0]          data
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_T4} state_t;

  localparam logic [2:0]  CMD_FETCH = 3'd0;
  localparam logic [2:0]  CMD_MRD   = 3'd1;
  localparam logic [2:0]  CMD_MWR   = 3'd2;
  localparam logic [2:0]  CMD_IORD  = 3'd3;
  localparam logic [2:0]  CMD_IOWR  = 3'd4;
  localparam bit          AW_EN     = (IO_AUTO_WAIT > 0);
  localparam bit          WT_EN     = (WAIT_TIMEOUT > 0);
  localparam logic [1:0]  AW_LAST   = 2'(IO_AUTO_WAIT - 1);
  localparam logic [15:0] WT_LAST   = 16'(WAIT_TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [2:0]  cmd_r, cmd_s;
  logic [15:0] addr_lat_r, addr_r, addr_s, cyc_addr_s;
  logic [7:0]  wdata_r, dout_r, dout_s, cyc_wdata_s;
  logic [7:0]  r_r, rdata_r;
  logic [1:0]  acnt_r;
  logic [15:0] wcnt_r;
  logic        busy_r, done_r, err_r, oe_r, oe_s;
  logic        mreq_r, iorq_r, rd_r, wr_r, m1_r, rfsh_r;
  logic        mreq_s, iorq_s, rd_s, wr_s, m1_s, rfsh_s;
  logic        accept_s, illegal_s, abort_s, finish_s, capture_s;
  logic        cur_fetch_s, cur_io_s, cur_rd_s;
  logic        fetch_s, io_s, rdc_s, wrc_s;

  // Classification of the cycle currently in progress.
  always_comb begin
    cur_fetch_s = (cmd_r == CMD_FETCH);
    cur_io_s    = (cmd_r == CMD_IORD) || (cmd_r == CMD_IOWR);
    cur_rd_s    = (cmd_r == CMD_MRD)  || (cmd_r == CMD_IORD);
  end

  // Next-state logic and cycle events (accept, illegal, abort, finish, capture).
  always_comb begin
    state_s   = state_r;
    cmd_s     = cmd_r;
    accept_s  = 1'b0;
    illegal_s = 1'b0;
    abort_s   = 1'b0;
    finish_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.req) begin
          if (bus.cmd <= CMD_IOWR) begin
            accept_s = 1'b1;
            cmd_s    = bus.cmd;
            state_s  = S_T1;
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_T1: state_s = S_T2;
      S_T2: begin
        if (cur_io_s && AW_EN) begin
          state_s = S_TWA;
        end else if (!bus.wait_n) begin
          state_s = S_TW;
        end else begin
          state_s = S_T3;
        end
      end
      S_TWA: begin
        // WAIT is only looked at once the last automatic wait is done.
        if (acnt_r == AW_LAST) begin
          state_s = bus.wait_n ? S_T3 : S_TW;
        end else begin
          state_s = S_TWA;
        end
      end
      S_TW: begin
        if (bus.wait_n) begin
          state_s = S_T3;
        end else if (WT_EN && (wcnt_r == WT_LAST)) begin
          abort_s = 1'b1;
          state_s = S_IDLE;
        end else begin
          state_s = S_TW;
        end
      end
      S_T3: begin
        if (cur_fetch_s) begin
          state_s = S_T4;
        end else begin
          finish_s = 1'b1;
          state_s  = S_IDLE;
        end
      end
      S_T4: begin
        finish_s = 1'b1;
        state_s  = S_IDLE;
      end
      default: state_s = S_IDLE;
    endcase
    // Fetch samples the opcode leaving T2/TW; plain reads sample leaving T3.
    if (cur_fetch_s && ((state_r == S_T2) || (state_r == S_TW)) && (state_s == S_T3)) begin
      capture_s = 1'b1;
    end else if (cur_rd_s && (state_r == S_T3)) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Bus outputs for the state being entered; registered on the same edge.
  always_comb begin
    fetch_s     = (cmd_s == CMD_FETCH);
    io_s        = (cmd_s == CMD_IORD) || (cmd_s == CMD_IOWR);
    rdc_s       = (cmd_s == CMD_MRD)  || (cmd_s == CMD_IORD);
    wrc_s       = (cmd_s == CMD_MWR)  || (cmd_s == CMD_IOWR);
    cyc_addr_s  = accept_s ? bus.addr_in : addr_lat_r;
    cyc_wdata_s = accept_s ? bus.wdata   : wdata_r;
    mreq_s = 1'b1;
    iorq_s = 1'b1;
    rd_s   = 1'b1;
    wr_s   = 1'b1;
    m1_s   = 1'b1;
    rfsh_s = 1'b1;
    oe_s   = 1'b0;
    dout_s = dout_r;
    addr_s = addr_r;
    case (state_s)
      S_T1: begin
        addr_s = cyc_addr_s;
        m1_s   = !fetch_s;
        oe_s   = wrc_s;
        dout_s = cyc_wdata_s;
      end
      S_T2, S_TWA, S_TW: begin
        addr_s = cyc_addr_s;
        m1_s   = !fetch_s;
        mreq_s = io_s;
        iorq_s = !io_s;
        rd_s   = !(fetch_s || rdc_s);
        wr_s   = !wrc_s;
        oe_s   = wrc_s;
        dout_s = cyc_wdata_s;
      end
      S_T3: begin
        if (fetch_s) begin
          // Refresh half of M1: R on the low address byte, MREQ released.
          addr_s = {8'h00, r_r};
          rfsh_s = 1'b0;
        end else begin
          addr_s = cyc_addr_s;
          mreq_s = io_s;
          iorq_s = !io_s;
          rd_s   = !rdc_s;
          wr_s   = !wrc_s;
          oe_s   = wrc_s;
          dout_s = cyc_wdata_s;
        end
      end
      S_T4: begin
        addr_s = {8'h00, r_r};
        rfsh_s = 1'b0;
        mreq_s = 1'b0;
      end
      S_IDLE:  addr_s = addr_r;
      default: addr_s = addr_r;
    endcase
  end

  // State, latched request, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      cmd_r      <= CMD_FETCH;
      addr_lat_r <= 16'h0000;
      wdata_r    <= 8'h00;
      r_r        <= 8'h00;
      acnt_r     <= 2'd0;
      wcnt_r     <= 16'h0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= 8'h00;
      addr_r     <= 16'h0000;
      dout_r     <= 8'h00;
      oe_r       <= 1'b0;
      mreq_r     <= 1'b1;
      iorq_r     <= 1'b1;
      rd_r       <= 1'b1;
      wr_r       <= 1'b1;
      m1_r       <= 1'b1;
      rfsh_r     <= 1'b1;
    end else begin
      state_r <= state_s;
      cmd_r   <= cmd_s;
      if (accept_s) begin
        addr_lat_r <= bus.addr_in;
        wdata_r    <= bus.wdata;
      end
      if (state_r == S_T4) begin
        r_r <= {r_r[7], r_r[6:0] + 7'd1};
      end
      acnt_r <= (state_r == S_TWA) ? acnt_r + 2'd1 : 2'd0;
      wcnt_r <= (state_r == S_TW) ? wcnt_r + 16'd1 : 16'h0000;
      if (capture_s) begin
        rdata_r <= data;
      end
      busy_r <= (state_s != S_IDLE);
      done_r <= finish_s || abort_s;
      err_r  <= abort_s || illegal_s;
      addr_r <= addr_s;
      dout_r <= dout_s;
      oe_r   <= oe_s;
      mreq_r <= mreq_s;
      iorq_r <= iorq_s;
      rd_r   <= rd_s;
      wr_r   <= wr_s;
      m1_r   <= m1_s;
      rfsh_r <= rfsh_s;
    end
  end

  assign data       = oe_r ? dout_r : 8'hzz;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;
  assign bus.rdata  = rdata_r;
  assign bus.addr   = addr_r;
  assign bus.mreq_n = mreq_r;
  assign bus.iorq_n = iorq_r;
  assign bus.rd_n   = rd_r;
  assign bus.wr_n   = wr_r;
  assign bus.m1_n   = m1_r;
  assign bus.rfsh_n = rfsh_r;

endmodule

// File: tb/tb_z80_cycle_master.sv
// Testbench for z80_cycle_master (IO_AUTO_WAIT = 1, WAIT_TIMEOUT = 4).
// Strobe vectors below are {mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n}.
module tb_z80_cycle_master;

  localparam logic [5:0] ST_IDLE = 6'b111111;
  localparam logic [5:0] ST_MRD  = 6'b010111;
  localparam logic [5:0] ST_MWR  = 6'b011011;
  localparam logic [5:0] ST_IOWR = 6'b101011;
  localparam logic [5:0] ST_F1   = 6'b111101;
  localparam logic [5:0] ST_F2   = 6'b010101;
  localparam logic [5:0] ST_F3   = 6'b111110;
  localparam logic [5:0] ST_F4   = 6'b011110;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       done;
    int         acc;
    int         lat;
  } exp_t;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  wire  [7:0] data;
  logic       tb_oe   = 1'b0;
  logic [7:0] tb_d    = 8'h00;
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         cyc = 0;

  exp_t       exp_q[$];
  logic [7:0] obs_rdata [64];
  logic       obs_err   [64];
  logic       obs_done  [64];
  int         obs_cyc   [64];
  int         obs_wr = 0;
  int         obs_rd = 0;

  z80_cycle_master_if bus();

  assign data = tb_oe ? tb_d : 8'hzz;

  z80_cycle_master #(.IO_AUTO_WAIT(1), .WAIT_TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .data    (data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every completion or error pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (reset_n && (bus.done || bus.err) && (obs_wr < 64)) begin
      obs_rdata[obs_wr] <= bus.rdata;
      obs_err[obs_wr]   <= bus.err;
      obs_done[obs_wr]  <= bus.done;
      obs_cyc[obs_wr]   <= cyc;
      obs_wr            <= obs_wr + 1;
    end
  end

  function automatic logic [5:0] strb();
    return {bus.mreq_n, bus.iorq_n, bus.rd_n, bus.wr_n, bus.m1_n, bus.rfsh_n};
  endfunction

  // Present a request for one edge; optionally queue its expected completion.
  task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [7:0] w,
                       input bit track, input logic [7:0] er, input logic ee,
                       input logic ed, input int el, output int acc);
    exp_t e;
    bus.req = 1'b1; bus.cmd = c; bus.addr_in = a; bus.wdata = w;
    @(posedge clk); #1;
    bus.req = 1'b0;
    acc = cyc;
    if (track) begin
      e.rdata = er; e.err = ee; e.done = ed; e.acc = acc; e.lat = el;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tb_oe = 1'b1; tb_d = 8'h3C;
    #1;
    tests_run++;
    if (strb() !== ST_IDLE) begin tests_failed++; $display("FAIL reset_strobes: got %b expected %b", strb(), ST_IDLE); end
    tests_run++;
    if ({bus.addr, bus.busy, bus.done, bus.err, bus.rdata} !== {16'h0000, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_status: got addr %h busy %b done %b err %b rdata %h expected 0000 0 0 0 00",
               bus.addr, bus.busy, bus.done, bus.err, bus.rdata);
    end
    tests_run++;
    if (data !== 8'h3C) begin tests_failed++; $display("FAIL reset_data_float: got %h expected 3c", data); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mem_read();
    int acc;
    logic [5:0] es;
    tb_oe = 1'b1; tb_d = 8'hA5; bus.wait_n = 1'b1;
    issue(3'b001, 16'h1234, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 3, acc);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      es = (i == 2 || i == 3) ? ST_MRD : ST_IDLE;
      tests_run++;
      if (strb() !== es) begin tests_failed++; $display("FAIL memrd_strobes c%0d: got %b expected %b", i, strb(), es); end
      if (i <= 3) begin
        tests_run++;
        if (bus.addr !== 16'h1234 || bus.busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL memrd_addr c%0d: got %h busy %b expected 1234 busy 1", i, bus.addr, bus.busy);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch();
    int acc;
    logic [5:0] es;
    logic [15:0] ea;
    tb_oe = 1'b1; tb_d = 8'hF3;
    for (int k = 0; k < 3; k++) begin
      issue(3'b000, 16'h0000, 8'h00, 1'b1, 8'hF3, 1'b0, 1'b1, 4, acc);
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        case (i)
          1:       es = ST_F1;
          2:       es = ST_F2;
          3:       es = ST_F3;
          4:       es = ST_F4;
          default: es = ST_IDLE;
        endcase
        tests_run++;
        if (strb() !== es) begin tests_failed++; $display("FAIL fetch%0d_strobes c%0d: got %b expected %b", k, i, strb(), es); end
        if (i == 3 || i == 4) begin
          ea = 16'(k);
          tests_run++;
          if (bus.addr !== ea) begin tests_failed++; $display("FAIL fetch%0d_refresh_addr c%0d: got %h expected %h", k, i, bus.addr, ea); end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_io_write_wait();
    int acc;
    logic [5:0] es;
    tb_oe = 1'b0;
    issue(3'b100, 16'h00C0, 8'h5A, 1'b1, 8'hF3, 1'b0, 1'b1, 6, acc);
    for (int i = 1; i <= 7; i++) begin
      bus.wait_n = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      if (i == 7) begin tb_oe = 1'b1; tb_d = 8'h3C; end
      @(negedge clk);
      es = (i >= 2 && i <= 6) ? ST_IOWR : ST_IDLE;
      tests_run++;
      if (strb() !== es) begin tests_failed++; $display("FAIL iowr_strobes c%0d: got %b expected %b", i, strb(), es); end
      tests_run++;
      if (i <= 6) begin
        if (data !== 8'h5A || bus.addr !== 16'h00C0) begin
          tests_failed++;
          $display("FAIL iowr_data c%0d: got data %h addr %h expected 5a 00c0", i, data, bus.addr);
        end
      end else begin
        if (data !== 8'h3C) begin tests_failed++; $display("FAIL iowr_release c%0d: got %h expected 3c", i, data); end
      end
      @(posedge clk); #1;
    end
    bus.wait_n = 1'b1;
  endtask

  task automatic test_timeout();
    int acc;
    logic [5:0] es;
    tb_oe = 1'b1; tb_d = 8'h77; bus.wait_n = 1'b0;
    issue(3'b001, 16'h8000, 8'h00, 1'b1, 8'hF3, 1'b1, 1'b1, 6, acc);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      es = (i >= 2 && i <= 6) ? ST_MRD : ST_IDLE;
      tests_run++;
      if (strb() !== es) begin tests_failed++; $display("FAIL timeout_strobes c%0d: got %b expected %b", i, strb(), es); end
      @(posedge clk); #1;
    end
    bus.wait_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    int acc;
    int snap;
    logic [5:0] es;
    tb_oe = 1'b0;
    snap = obs_wr;
    issue(3'b010, 16'h4000, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 0, acc);
    @(negedge clk);
    tests_run++;
    if (data !== 8'h99) begin tests_failed++; $display("FAIL abort_t1_data: got %h expected 99", data); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (strb() !== ST_MWR) begin tests_failed++; $display("FAIL abort_t2_strobes: got %b expected %b", strb(), ST_MWR); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (strb() !== ST_IDLE || bus.addr !== 16'h0000 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_reset_state: got %b addr %h busy %b expected %b 0000 0", strb(), bus.addr, bus.busy, ST_IDLE);
    end
    tb_oe = 1'b1; tb_d = 8'h3C;
    #1;
    tests_run++;
    if (data !== 8'h3C) begin tests_failed++; $display("FAIL abort_data_float: got %h expected 3c", data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (obs_wr !== snap) begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses expected 0", obs_wr - snap); end
    tb_d = 8'hC3;
    issue(3'b001, 16'h5555, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b1, 3, acc);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      es = (i == 2 || i == 3) ? ST_MRD : ST_IDLE;
      tests_run++;
      if (strb() !== es) begin tests_failed++; $display("FAIL post_reset_strobes c%0d: got %b expected %b", i, strb(), es); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    int acc;
    issue(3'b111, 16'h1357, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b0, 0, acc);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (strb() !== ST_IDLE || bus.busy !== 1'b0 || bus.err !== (i == 1)) begin
        tests_failed++;
        $display("FAIL illegal c%0d: got strobes %b busy %b err %b expected %b 0 %b", i, strb(), bus.busy, bus.err, ST_IDLE, (i == 1));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2;
    logic [5:0] es;
    tb_oe = 1'b1; tb_d = 8'h42;
    issue(3'b001, 16'h1111, 8'h00, 1'b1, 8'h42, 1'b0, 1'b1, 3, acc1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      es = (i >= 2) ? ST_MRD : ST_IDLE;
      tests_run++;
      if (strb() !== es) begin tests_failed++; $display("FAIL b2b_rd_strobes c%0d: got %b expected %b", i, strb(), es); end
      @(posedge clk); #1;
    end
    tb_oe = 1'b0;
    issue(3'b010, 16'h2222, 8'h24, 1'b1, 8'h42, 1'b0, 1'b1, 3, acc2);
    tests_run++;
    if (acc2 - acc1 !== 4) begin tests_failed++; $display("FAIL b2b_gap: got %0d cycles expected 4", acc2 - acc1); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      es = (i == 2 || i == 3) ? ST_MWR : ST_IDLE;
      tests_run++;
      if (strb() !== es) begin tests_failed++; $display("FAIL b2b_wr_strobes c%0d: got %b expected %b", i, strb(), es); end
      if (i <= 3) begin
        tests_run++;
        if (data !== 8'h24 || bus.addr !== 16'h2222) begin
          tests_failed++;
          $display("FAIL b2b_wr_data c%0d: got %h addr %h expected 24 2222", i, data, bus.addr);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_rd >= obs_wr) begin
        tests_failed++;
        $display("FAIL sb_missing: no pulse seen, expected rdata %h err %b done %b", e.rdata, e.err, e.done);
      end else begin
        if (obs_rdata[obs_rd] !== e.rdata || obs_err[obs_rd] !== e.err ||
            obs_done[obs_rd] !== e.done || (obs_cyc[obs_rd] - e.acc) !== e.lat) begin
          tests_failed++;
          $display("FAIL sb_entry%0d: got rdata %h err %b done %b lat %0d expected %h %b %b %0d", obs_rd,
                   obs_rdata[obs_rd], obs_err[obs_rd], obs_done[obs_rd], obs_cyc[obs_rd] - e.acc,
                   e.rdata, e.err, e.done, e.lat);
        end
        obs_rd++;
      end
    end
    tests_run++;
    if (obs_rd !== obs_wr) begin tests_failed++; $display("FAIL sb_extra: got %0d unexpected pulses expected 0", obs_wr - obs_rd); end
  endtask

  initial begin
    bus.req = 1'b0; bus.cmd = 3'b000; bus.addr_in = 16'h0000; bus.wdata = 8'h00; bus.wait_n = 1'b1;
    test_reset();
    test_mem_read();
    test_fetch();
    test_io_write_wait();
    test_timeout();
    test_reset_abort();
    test_illegal();
    test_back_to_back();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
